// File: rtl/sqrt_csa_arbiter.sv
// Two-requester arbiter time-sharing one 14-bit sqrt carry-select adder for 28-bit add (optional subtract via SQRT_CSA_ARBITER_SUB_EN).
// Latency: grant at cycle T, result valid from T+3 (IDLE->LO->HI->DONE), at most one operation per 4 cycles.
// Backpressure: result held in DONE until rsp_ready; no requester is granted again until DONE has exited.

// 14-bit square-root carry-select adder: ripple block of 2, then select blocks of 3, 4 and 5 bits.
module sqrt_csa14 (
  input  logic [13:0] a,
  input  logic [13:0] b,
  input  logic        cin,
  output logic [13:0] sum,
  output logic        cout
);

  logic       c2;
  logic       c5;
  logic       c9;
  logic [3:0] blk1_c0;
  logic [3:0] blk1_c1;
  logic [4:0] blk2_c0;
  logic [4:0] blk2_c1;
  logic [5:0] blk3_c0;
  logic [5:0] blk3_c1;

  // First block ripples directly from the incoming carry.
  assign {c2, sum[1:0]} = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};

  // Upper blocks precompute both carry-in cases; the carry chain only drives the selects.
  assign blk1_c0 = {1'b0, a[4:2]}  + {1'b0, b[4:2]};
  assign blk1_c1 = {1'b0, a[4:2]}  + {1'b0, b[4:2]}  + 4'd1;
  assign blk2_c0 = {1'b0, a[8:5]}  + {1'b0, b[8:5]};
  assign blk2_c1 = {1'b0, a[8:5]}  + {1'b0, b[8:5]}  + 5'd1;
  assign blk3_c0 = {1'b0, a[13:9]} + {1'b0, b[13:9]};
  assign blk3_c1 = {1'b0, a[13:9]} + {1'b0, b[13:9]} + 6'd1;

  assign {c5,   sum[4:2]}  = c2 ? blk1_c1 : blk1_c0;
  assign {c9,   sum[8:5]}  = c5 ? blk2_c1 : blk2_c0;
  assign {cout, sum[13:9]} = c9 ? blk3_c1 : blk3_c0;

endmodule

module sqrt_csa_arbiter #(
  parameter int FAIR_RR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [27:0] req0_a,
  input  logic [27:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [27:0] req1_a,
  input  logic [27:0] req1_b,
  input  logic        req1_sub,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [27:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_id,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  typedef struct packed {
    logic [27:0] a;
    logic [27:0] b;
    logic        id;
  } op_t;

  state_t      state;
  op_t         op_q;
  logic        carry_lo;
  logic        last_grant;
  logic [27:0] result;
  logic        cout_q;
  logic        rsp_valid_q;
  logic        busy_q;

  logic        grant_vld;
  logic        grant_id;
  logic        take;

  logic [13:0] add_a;
  logic [13:0] b_raw;
  logic [13:0] add_b;
  logic        add_cin;
  logic [13:0] add_sum;
  logic        add_cout;

`ifdef SQRT_CSA_ARBITER_SUB_EN
  logic        sub_q;
`else
  // Subtract inputs have no function in the add-only build.
  logic        unused_sub;
  assign unused_sub = req0_sub ^ req1_sub;
`endif

  // Pick the winner: round-robin alternates on contention, fixed mode always favours req0.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = (FAIR_RR != 0) ? ~last_grant : 1'b0;
    end else begin
      grant_id = ~req0_valid;
    end
  end

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign take       = rst_n && (state == IDLE) && grant_vld;
  assign req0_ready = take & ~grant_id;
  assign req1_ready = take &  grant_id;

  // Steer the low or high operand halves into the shared adder.
  always_comb begin
    add_a   = op_q.a[13:0];
    b_raw   = op_q.b[13:0];
    add_cin = 1'b0;
    if (state == HI) begin
      add_a   = op_q.a[27:14];
      b_raw   = op_q.b[27:14];
      add_cin = carry_lo;
    end
`ifdef SQRT_CSA_ARBITER_SUB_EN
    add_b = sub_q ? ~b_raw : b_raw;
    if (state != HI) begin
      add_cin = sub_q;
    end
`else
    add_b = b_raw;
`endif
  end

  sqrt_csa14 u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Operation sequencer: capture on grant, two adder passes, then hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      carry_lo    <= 1'b0;
      last_grant  <= 1'b1;
      result      <= '0;
      cout_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SQRT_CSA_ARBITER_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            op_q.a     <= grant_id ? req1_a : req0_a;
            op_q.b     <= grant_id ? req1_b : req0_b;
            op_q.id    <= grant_id;
`ifdef SQRT_CSA_ARBITER_SUB_EN
            sub_q      <= grant_id ? req1_sub : req0_sub;
`endif
            last_grant <= grant_id;
            busy_q     <= 1'b1;
            state      <= LO;
          end
        end
        LO: begin
          result[13:0] <= add_sum;
          carry_lo     <= add_cout;
          state        <= HI;
        end
        HI: begin
          result[27:14] <= add_sum;
          cout_q        <= add_cout;
          rsp_valid_q   <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = result;
  assign rsp_cout  = cout_q;
  assign rsp_id    = op_q.id;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sqrt_csa_arbiter.sv
// Directed bench for sqrt_csa_arbiter: round-robin instance plus a fixed-priority instance on shared inputs.
// Checks reset state, add results across the pass boundary, latency, DONE hold, abort-on-reset and arbitration order.
module tb_sqrt_csa_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic        req1_valid;
  logic [27:0] req0_a;
  logic [27:0] req0_b;
  logic [27:0] req1_a;
  logic [27:0] req1_b;
  logic        req0_sub;
  logic        req1_sub;
  logic        rsp_ready;

  logic        req0_ready;
  logic        req1_ready;
  logic        rsp_valid;
  logic [27:0] rsp_sum;
  logic        rsp_cout;
  logic        rsp_id;
  logic        busy;

  logic        fp_req0_ready;
  logic        fp_req1_ready;
  logic        fp_rsp_valid;
  logic [27:0] fp_rsp_sum;
  logic        fp_rsp_cout;
  logic        fp_rsp_id;
  logic        fp_busy;

  int vectors;
  int miscompares;

`ifdef SQRT_CSA_ARBITER_SUB_EN
  localparam logic [27:0] SUB_EXP = 28'hFFFFFFE;
`else
  localparam logic [27:0] SUB_EXP = 28'h000000C;
`endif

  sqrt_csa_arbiter #(.FAIR_RR(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  sqrt_csa_arbiter #(.FAIR_RR(0)) dut_fp (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (fp_req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (fp_req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp_valid  (fp_rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (fp_rsp_sum),
    .rsp_cout   (fp_rsp_cout),
    .rsp_id     (fp_rsp_id),
    .busy       (fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk28(input string tag, input logic [27:0] obs, input logic [27:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%07h expected=%07h", tag, obs, exp_v);
    end
  endtask

  // One operation from a single requester, with noise on the inputs while it is in flight.
  task automatic run_op(input string tag, input logic id, input logic [27:0] a, input logic [27:0] b,
                        input logic sub, input logic [27:0] exp_sum, input logic exp_cout, input int hold);
    @(negedge clk);
    req0_valid = ~id;
    req1_valid = id;
    if (id) begin
      req1_a = a; req1_b = b; req1_sub = sub;
      req0_a = 28'h0; req0_b = 28'h0; req0_sub = 1'b0;
    end else begin
      req0_a = a; req0_b = b; req0_sub = sub;
      req1_a = 28'h0; req1_b = 28'h0; req1_sub = 1'b0;
    end
    #1;
    chk1({tag, ":grant_rdy0"}, req0_ready, ~id);
    chk1({tag, ":grant_rdy1"}, req1_ready, id);
    // LO: change everything on the request side; the captured operation must not notice.
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 28'h5A5A5A5; req0_b = 28'hA5A5A5A; req0_sub = ~sub;
    req1_a = 28'h3C3C3C3; req1_b = 28'hC3C3C3C; req1_sub = ~sub;
    #1;
    chk1({tag, ":lo_busy"}, busy, 1'b1);
    chk1({tag, ":lo_vld"}, rsp_valid, 1'b0);
    chk1({tag, ":lo_rdy0"}, req0_ready, 1'b0);
    chk1({tag, ":lo_rdy1"}, req1_ready, 1'b0);
    @(negedge clk);
    chk1({tag, ":hi_vld"}, rsp_valid, 1'b0);
    chk1({tag, ":hi_rdy0"}, req0_ready, 1'b0);
    @(negedge clk);
    chk1({tag, ":t3_vld"}, rsp_valid, 1'b1);
    chk28({tag, ":sum"}, rsp_sum, exp_sum);
    chk1({tag, ":cout"}, rsp_cout, exp_cout);
    chk1({tag, ":id"}, rsp_id, id);
    chk1({tag, ":done_rdy0"}, req0_ready, 1'b0);
    chk1({tag, ":done_rdy1"}, req1_ready, 1'b0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk1({tag, ":hold_vld"}, rsp_valid, 1'b1);
      chk28({tag, ":hold_sum"}, rsp_sum, exp_sum);
      chk1({tag, ":hold_cout"}, rsp_cout, exp_cout);
      chk1({tag, ":hold_id"}, rsp_id, id);
      chk1({tag, ":hold_rdy0"}, req0_ready, 1'b0);
      chk1({tag, ":hold_rdy1"}, req1_ready, 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk1({tag, ":exit_vld"}, rsp_valid, 1'b0);
    chk1({tag, ":exit_busy"}, busy, 1'b0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_a = 28'h0; req0_b = 28'h0; req0_sub = 1'b0;
    req1_a = 28'h0; req1_b = 28'h0; req1_sub = 1'b0;
    rsp_ready  = 1'b0;

    // Reset: outputs low even with both requesters asking.
    repeat (2) @(negedge clk);
    chk1("rst_rdy0", req0_ready, 1'b0);
    chk1("rst_rdy1", req1_ready, 1'b0);
    chk1("rst_vld", rsp_valid, 1'b0);
    chk28("rst_sum", rsp_sum, 28'h0);
    chk1("rst_cout", rsp_cout, 1'b0);
    chk1("rst_id", rsp_id, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n      = 1'b1;

    // Carry crossing the 14-bit pass boundary.
    run_op("carry14", 1'b0, 28'h0003FFF, 28'h0000001, 1'b0, 28'h0004000, 1'b0, 0);
    // Full wrap with carry out, from requester 1.
    run_op("wrap", 1'b1, 28'hFFFFFFF, 28'h0000001, 1'b0, 28'h0000000, 1'b1, 0);
    // Mixed pattern, result held 5 cycles with rsp_ready low.
    run_op("mixed_hold", 1'b0, 28'h0ABCDEF, 28'h1234567, 1'b0, 28'h1CF1356, 1'b0, 5);
    // All ones plus all ones exercises every select block with carry in.
    run_op("ones", 1'b0, 28'hFFFFFFF, 28'hFFFFFFF, 1'b0, 28'hFFFFFFE, 1'b1, 0);
    // Subtract request: honoured only when the subtract build is selected.
    run_op("sub", 1'b1, 28'h0000005, 28'h0000007, 1'b1, SUB_EXP, 1'b0, 0);

    // Abort in HI with reset.
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 28'h0000001; req1_b = 28'h0000002; req1_sub = 1'b0;
    #1;
    chk1("abort_grant", req1_ready, 1'b1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_vld", rsp_valid, 1'b0);
    chk28("abort_sum", rsp_sum, 28'h0);
    chk1("abort_cout", rsp_cout, 1'b0);
    chk1("abort_id", rsp_id, 1'b0);
    chk1("abort_rdy0", req0_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("post_rst_vld", rsp_valid, 1'b0);
      chk1("post_rst_busy", busy, 1'b0);
    end

    // Contention every cycle: round-robin alternates, fixed priority sticks to req0.
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int g = 0; g < 3; g++) begin
      #1;
      chk1("rr_rdy0", req0_ready, (g % 2) == 0);
      chk1("rr_rdy1", req1_ready, (g % 2) == 1);
      chk1("fp_rdy0", fp_req0_ready, 1'b1);
      chk1("fp_rdy1", fp_req1_ready, 1'b0);
      repeat (3) @(negedge clk);
      chk1("rr_done_vld", rsp_valid, 1'b1);
      chk1("rr_done_id", rsp_id, (g % 2) == 1);
      chk1("fp_done_id", fp_rsp_id, 1'b0);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
